// File: rtl/pft_writer.sv
// Prefetch-table writer: steers a stream of entry beats into per-bank write ports.
// Define PFT_WR_OVF_EN to hold full banks and flag overflow instead of wrapping.
module pft_writer #(
    parameter int PFT_addr_width = 5,
    parameter int PFT_data_width = 8,
    parameter int PE_COL         = 16,
    parameter int PFT_bank       = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PFT_data_width*PE_COL-1:0] in_data,
    input  logic [PFT_addr_width-1:0]        in_bank,
    input  logic                             in_last,
    output logic [PFT_bank-1:0]              write,
    output logic [PFT_addr_width-1:0]        PFT_waddr,
    output logic [PFT_data_width*PE_COL-1:0] din,
    output logic [PFT_bank-1:0]              valid,
    output logic                             done,
    output logic                             overflow
);
    localparam int AW = PFT_addr_width;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                   state, state_nxt;
    logic [AW-1:0]            ptr [PFT_bank];
    logic [PFT_bank-1:0]      hit;
    logic [AW-1:0]            cur_ptr;
    logic                     accept, in_range, drop, do_write;

    assign accept   = in_valid && in_ready;
    assign in_range = int'(in_bank) < PFT_bank;

    always_comb begin
        hit     = '0;
        cur_ptr = '0;
        for (int b = 0; b < PFT_bank; b++) begin
            hit[b] = (int'(in_bank) == b);
            if (hit[b]) cur_ptr = ptr[b];
        end
    end

`ifdef PFT_WR_OVF_EN
    logic [PFT_bank-1:0] full;
    logic                bank_full;

    assign bank_full = |(full & hit);
    assign drop      = !in_range || bank_full;

    // A bank becomes full on the write that lands at the last address.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            full <= '0;
        end else begin
            for (int b = 0; b < PFT_bank; b++)
                if (do_write && hit[b] && (&ptr[b])) full[b] <= 1'b1;
        end
    end
`else
    assign drop = !in_range;
`endif

    assign do_write = accept && !drop;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    ;
            LOAD: begin
                in_ready = !start;
                if (in_valid && !start && in_last) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = DONE;
            DONE:    done = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            valid <= '0;
            for (int b = 0; b < PFT_bank; b++) ptr[b] <= '0;
        end else begin
            for (int b = 0; b < PFT_bank; b++) begin
                if (do_write && hit[b]) begin
                    ptr[b]   <= ptr[b] + AW'(1);
                    valid[b] <= 1'b1;
                end
            end
        end
    end

    // Write port is registered: one cycle after acceptance, strobe for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            write     <= '0;
            PFT_waddr <= '0;
            din       <= '0;
            overflow  <= 1'b0;
        end else begin
            write <= '0;
            if (do_write) begin
                write     <= hit;
                PFT_waddr <= cur_ptr;
                din       <= in_data;
            end
            if (start)               overflow <= 1'b0;
            else if (accept && drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pft_writer.sv
// Scoreboard bench for pft_writer: randomized beats against a per-bank write-count model.
module tb_pft_writer;
    localparam int NB = 32;
    localparam int DEPTH = 32;
`ifdef PFT_WR_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, in_valid, in_last;
    logic [127:0] in_data;
    logic [4:0]   in_bank;
    logic         in_ready, done, overflow;
    logic [31:0]  write, valid;
    logic [4:0]   waddr;
    logic [127:0] din;

    logic         in_ready16, done16, ov16;
    logic [15:0]  write16, valid16;
    logic [4:0]   waddr16;
    logic [127:0] din16;

    pft_writer u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_bank(in_bank), .in_last(in_last), .write(write),
        .PFT_waddr(waddr), .din(din), .valid(valid), .done(done), .overflow(overflow));

    pft_writer #(.PFT_bank(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .in_bank(in_bank), .in_last(in_last), .write(write16),
        .PFT_waddr(waddr16), .din(din16), .valid(valid16), .done(done16), .overflow(ov16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [31:0]  oh;
        logic [4:0]   addr;
        logic [127:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          cnt[NB];
    logic [31:0] m_valid;
    logic        m_ovf;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: any write strobe must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (write != 0) begin
            if (exp_q.size() == 0) chk("spurious_write", write, 32'h0);
            else begin
                e = exp_q.pop_front();
                chk("write_cycle", 128'(cyc), 128'(e.cyc));
                chk("write_onehot", write, e.oh);
                chk("waddr", waddr, e.addr);
                chk("din", din, e.data);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("write_missing", write, e.oh);
        end
    end

    task automatic model_clear();
        for (int b = 0; b < NB; b++) cnt[b] = 0;
        m_valid = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    // Drive one beat in LOAD; it is accepted on the next edge.
    task automatic beat(input int bank, input logic [127:0] d, input bit last);
        exp_t e;
        in_valid = 1'b1; in_bank = 5'(bank); in_data = d; in_last = last;
        #1 chk("in_ready", in_ready, 1'b1);
        if (OVF && cnt[bank] >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            e.cyc  = cyc + 1;
            e.oh   = 32'h1 << bank;
            e.addr = 5'(cnt[bank] % DEPTH);
            e.data = d;
            exp_q.push_back(e);
            m_valid[bank] = 1'b1;
        end
        cnt[bank]++;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_done_seq(input string nm);
        chk({nm, "_flush_done"}, done, 1'b0);
        tick();
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_valid"}, valid, m_valid);
        chk({nm, "_overflow"}, overflow, m_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_bank = '0;
        model_clear();
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_write", write, 32'h0);
        chk("rst_waddr", waddr, 5'h0);
        chk("rst_din", din, 128'h0);
        chk("rst_valid", valid, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1'b0);

        // Three beats to bank 4.
        do_start();
        beat(4, {16{8'hAA}}, 0);
        beat(4, {16{8'hBB}}, 0);
        beat(4, {16{8'hCC}}, 1);
        chk("a_valid_const", valid, 32'h10);
        check_done_seq("a");

        // Interleaved banks; the 16-bank instance drops bank 31.
        do_start();
        beat(0, rnd128(), 0);
        beat(31, rnd128(), 0);
        chk("b16_no_write", write16, 16'h0);
        chk("b16_overflow", ov16, 1'b1);
        beat(0, rnd128(), 1);
        chk("b16_write", write16, 16'h1);
        chk("b16_waddr", waddr16, 5'd1);
        chk("b16_din", din16, din);
        chk("b_valid_const", valid, 32'h8000_0001);
        chk("b16_valid", valid16, 16'h0001);
        check_done_seq("b");
        chk("b16_done", done16, 1'b1);

        // Fill bank 7 past its depth.
        do_start();
        for (int i = 0; i < 33; i++) beat(7, rnd128(), i == 32);
        chk("c_overflow_const", overflow, OVF);
        check_done_seq("c");

        // start in DONE together with a beat: beat refused, table cleared.
        start = 1'b1; in_valid = 1'b1; in_bank = 5'd4; in_data = rnd128();
        #1 chk("d_in_ready", in_ready, 1'b0);
        chk("d_in_ready16", in_ready16, 1'b0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        model_clear();
        chk("d_valid_clr", valid, 32'h0);
        chk("d_overflow_clr", overflow, 1'b0);
        chk("d_done_clr", done, 1'b0);
        beat(4, rnd128(), 1);
        check_done_seq("d");

        // Beats outside LOAD are ignored.
        in_valid = 1'b1; in_bank = 5'd9; in_data = rnd128();
        repeat (3) begin
            #1 chk("stray_in_ready", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("stray_valid", valid, m_valid);

        // Random traffic with idle gaps.
        do_start();
        for (int i = 0; i < 120; i++) begin
            beat(int'($urandom_range(0, NB - 1)), rnd128(), i == 119);
            if (i != 119) repeat ($urandom_range(0, 2)) tick();
        end
        check_done_seq("rand");

        // Reset the cycle after an accepted beat.
        do_start();
        beat(5, rnd128(), 0);
        rst = 1'b1;
        tick();
        model_clear();
        chk("r_write", write, 32'h0);
        chk("r_waddr", waddr, 5'h0);
        chk("r_din", din, 128'h0);
        chk("r_valid", valid, 32'h0);
        chk("r_in_ready", in_ready, 1'b0);
        chk("r_done", done, 1'b0);
        chk("r_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();
        do_start();
        beat(5, rnd128(), 1);
        check_done_seq("r");

        repeat (3) tick();
        chk("queue_drained", 128'(exp_q.size()), 128'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pft_writer.md
PFT_WRITER -- requirements
Module: pft_writer

Interface
REQ-001 Parameters SHALL be: PFT_addr_width, default 5, per-bank entry address width; PFT_data_width, default 8, element width; PE_COL, default 16, elements per entry; PFT_bank, default 32, bank count.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports listed below, clock and reset first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle pulse; clears the table and begins a load.
REQ-006 in_valid  input  1  beat valid.
REQ-007 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 in_data  input  PFT_data_width*PE_COL  entry payload.
REQ-009 in_bank  input  PFT_addr_width  target bank index, 0..PFT_bank-1.
REQ-010 in_last  input  1  marks the final beat of the load.
REQ-011 write  output  PFT_bank  one-hot per-bank write enable.
REQ-012 PFT_waddr  output  PFT_addr_width  shared write address.
REQ-013 din  output  PFT_data_width*PE_COL  write data.
REQ-014 valid  output  PFT_bank  bank-occupied mask; bit i set when bank i holds at least one entry.
REQ-015 done  output  1  level; high while the load is complete.
REQ-016 overflow  output  1  sticky; high when a beat targeted a full bank.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, FLUSH, DONE.
REQ-018 Transitions: any state with start -> LOAD; LOAD with accepted in_last beat -> FLUSH; FLUSH -> DONE unconditionally; DONE holds until start.
REQ-019 On start, all per-bank write pointers, valid, and overflow SHALL clear on the same edge.
REQ-020 in_ready SHALL equal (state==LOAD) && !start; start in the same cycle as in_valid means the beat is not accepted.
REQ-021 Each bank SHALL keep its own PFT_addr_width-bit write pointer; an accepted beat writes at the pointer of in_bank, and that pointer increments by 1.
REQ-022 Latency: a beat accepted in cycle n SHALL drive write (one-hot at in_bank), PFT_waddr, and din in cycle n+1 only; write is all-zero in every other cycle.
REQ-023 valid[in_bank] SHALL set in cycle n+1, together with the write.
REQ-024 done SHALL be high in DONE only, i.e. from cycle n+2 after the in_last beat.
REQ-025 in_bank >= PFT_bank SHALL be dropped: no write, pointer unchanged, overflow set.
REQ-026 Back-to-back beats to the same bank SHALL produce consecutive addresses with no bubble.
REQ-027 Beats outside LOAD SHALL be ignored.

Reset
REQ-028 On rst, state SHALL be IDLE; in_ready, write, PFT_waddr, din, valid, done, and overflow SHALL be 0; all pointers SHALL be 0.
REQ-029 rst SHALL take priority over start; rst mid-load SHALL abort the load with no further writes.

Configuration
REQ-030 Macro PFT_WR_OVF_EN defined: a bank is full after 2^PFT_addr_width writes; a further beat to it is accepted and dropped (no write, pointer held), and overflow is set.
REQ-031 PFT_WR_OVF_EN undefined: the pointer wraps from 2^PFT_addr_width-1 to 0 and overwrites; overflow is tied to 0, except that the out-of-range case of REQ-025 still sets it.

Verification
REQ-032 rst, then start, then 3 beats to bank 4 with data 0xA..,0xB..,0xC.. (last on the 3rd) -> write=32'h10 at addresses 0,1,2 in consecutive cycles; valid=32'h10; done high 2 cycles after the last beat.
REQ-033 Interleave beats bank0, bank31, bank0 -> addresses 0,0,1; valid=32'h8000_0001.
REQ-034 With PFT_WR_OVF_EN defined, 33 beats to bank 7 -> 32 writes at addresses 0..31; 33rd beat produces no write and overflow=1. Without the macro, the 33rd write goes to address 0 and overflow=0.
REQ-035 start asserted in DONE with in_valid high in the same cycle -> in_ready=0 that cycle; valid, overflow, and pointers cleared; the next beat to bank 4 writes address 0.
REQ-036 rst asserted the cycle after an accepted beat -> write=0 from the reset edge onward; all outputs 0.
REQ-037 in_bank=5'd31 with PFT_bank=16 -> no write and overflow=1.
